// File: rtl/bram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bram_arbiter_pkg
//   Shared definitions for the two-requester BRAM port arbiter:
//   sequencer state encoding, requester count, default data/address widths
//   and a small index-to-one-hot helper.
// ----------------------------------------------------------------------------
package bram_arbiter_pkg;

  localparam int NUM_REQUESTERS     = 2;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 16;

  // Sequencer states. Encoding 2'd3 is unused and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_READ   = 2'd2
  } state_t;

  // Turn a requester index into a one-hot per-requester vector.
  function automatic logic [NUM_REQUESTERS-1:0] idx_to_onehot(input logic idx);
    logic [NUM_REQUESTERS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/bram_arbiter_select.sv
// ----------------------------------------------------------------------------
// bram_arbiter_select
//   Combinational winner selection for the two requesters.
//   Build option: BRAM_ARBITER_FIXED_PRIORITY_EN
//     defined   - requester 0 always wins a tie, ptr is ignored
//     undefined - a tie goes to the requester named by ptr
//   Ports:
//     req  in  NUM_REQUESTERS  active requests, bit n = requester n
//     ptr  in  1               preferred requester on a tie
//     gnt  out NUM_REQUESTERS  one-hot winner (all zero when no request)
// ----------------------------------------------------------------------------
module bram_arbiter_select
  import bram_arbiter_pkg::*;
(
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic                      ptr,
  output logic [NUM_REQUESTERS-1:0] gnt
);

`ifdef BRAM_ARBITER_FIXED_PRIORITY_EN
  // Pointer has no meaning with fixed priority.
  logic unused_ptr;
  assign unused_ptr = ptr;

  assign gnt[0] = req[0];
  assign gnt[1] = req[1] & ~req[0];
`else
  // A requester wins if it asks and either the other one is silent or the
  // pointer prefers it. Exactly one of the two can satisfy this on a tie.
  genvar gi;
  for (gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_sel
    assign gnt[gi] = req[gi] & (~req[1-gi] | (ptr == 1'(gi)));
  end
`endif

endmodule

// File: rtl/bram_arbiter.sv
// ----------------------------------------------------------------------------
// bram_arbiter
//   Two-requester arbiter/sequencer for one port of a synchronous-read BRAM.
//   Grants one request at a time, drives the BRAM port, waits out the read
//   latency and returns read data (O_RDATA) or a write acknowledge (O_VALID).
//   Build option: BRAM_ARBITER_FIXED_PRIORITY_EN (fixed priority to
//   requester 0 instead of round-robin).
//   Ports:
//     I_CLK, I_NRESET               clock, asynchronous active-low reset
//     I_REQ/I_WE [1:0]              per-requester request / write flag
//     I_ADDR/I_WDATA                packed per-requester address / write data
//     O_GNT/O_VALID [1:0]           one-cycle accept / completion pulses
//     O_RDATA                       last read data (held between reads)
//     O_BRAM_ADDRESS/DATA/WRITE_ENABLE  to the BRAM port
//     I_BRAM_DATA                   from the BRAM port
//   All outputs are registered and reset to 0.
// ----------------------------------------------------------------------------
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                                 I_CLK,
  input  logic                                 I_NRESET,
  input  logic [NUM_REQUESTERS-1:0]            I_REQ,
  input  logic [NUM_REQUESTERS-1:0]            I_WE,
  input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] I_ADDR,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] I_WDATA,
  output logic [NUM_REQUESTERS-1:0]            O_GNT,
  output logic [NUM_REQUESTERS-1:0]            O_VALID,
  output logic [DATA_WIDTH-1:0]                O_RDATA,
  output logic [ADDR_WIDTH-1:0]                O_BRAM_ADDRESS,
  output logic [DATA_WIDTH-1:0]                O_BRAM_DATA,
  output logic                                 O_BRAM_WRITE_ENABLE,
  input  logic [DATA_WIDTH-1:0]                I_BRAM_DATA
);

  // Unpacked per-requester operands.
  logic [ADDR_WIDTH-1:0] req_addr  [NUM_REQUESTERS];
  logic [DATA_WIDTH-1:0] req_wdata [NUM_REQUESTERS];

  genvar gi;
  for (gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_unpack
    assign req_addr[gi]  = I_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_wdata[gi] = I_WDATA[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  state_t                    state_reg, state_next;
  logic [NUM_REQUESTERS-1:0] gnt_reg, gnt_next;
  logic [NUM_REQUESTERS-1:0] valid_reg, valid_next;
  logic [DATA_WIDTH-1:0]     rdata_reg, rdata_next;
  logic [ADDR_WIDTH-1:0]     baddr_reg, baddr_next;
  logic [DATA_WIDTH-1:0]     bdata_reg, bdata_next;
  logic                      bwe_reg, bwe_next;
  logic                      owner_reg, owner_next;   // index of granted requester
  logic                      we_lat_reg, we_lat_next; // latched write flag

  logic [NUM_REQUESTERS-1:0] sel_gnt;
  logic                      winner;
  logic                      ptr_pref;
  logic                      grant_now;

  assign winner    = sel_gnt[1];
  assign grant_now = (state_reg == S_IDLE) && (|I_REQ);

`ifdef BRAM_ARBITER_FIXED_PRIORITY_EN
  assign ptr_pref = 1'b0;
`else
  // Round-robin pointer: names the preferred requester on a tie. After each
  // grant it moves to the requester that was not just served.
  logic ptr_reg;

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      ptr_reg <= 1'b0;
    end else if (grant_now) begin
      ptr_reg <= ~winner;
    end
  end

  assign ptr_pref = ptr_reg;
`endif

  bram_arbiter_select u_select (
    .req (I_REQ),
    .ptr (ptr_pref),
    .gnt (sel_gnt)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_next  = state_reg;
    gnt_next    = '0;
    valid_next  = '0;
    rdata_next  = rdata_reg;
    baddr_next  = baddr_reg;
    bdata_next  = bdata_reg;
    bwe_next    = 1'b0;       // WE is a single-cycle pulse in S_ACCESS
    owner_next  = owner_reg;
    we_lat_next = we_lat_reg;

    case (state_reg)
      S_IDLE: begin
        if (grant_now) begin
          gnt_next    = sel_gnt;
          owner_next  = winner;
          we_lat_next = I_WE[winner];
          // The BRAM port registers double as the operand latch.
          baddr_next  = req_addr[winner];
          bdata_next  = req_wdata[winner];
          bwe_next    = I_WE[winner];
          state_next  = S_ACCESS;
        end
      end

      S_ACCESS: begin
        // BRAM samples the port at the end of this cycle.
        if (we_lat_reg) begin
          valid_next = idx_to_onehot(owner_reg);
          state_next = S_IDLE;
        end else begin
          state_next = S_READ;
        end
      end

      S_READ: begin
        // BRAM output is valid during this cycle; capture it.
        rdata_next = I_BRAM_DATA;
        valid_next = idx_to_onehot(owner_reg);
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_reg  <= S_IDLE;
      gnt_reg    <= '0;
      valid_reg  <= '0;
      rdata_reg  <= '0;
      baddr_reg  <= '0;
      bdata_reg  <= '0;
      bwe_reg    <= 1'b0;
      owner_reg  <= 1'b0;
      we_lat_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      valid_reg  <= valid_next;
      rdata_reg  <= rdata_next;
      baddr_reg  <= baddr_next;
      bdata_reg  <= bdata_next;
      bwe_reg    <= bwe_next;
      owner_reg  <= owner_next;
      we_lat_reg <= we_lat_next;
    end
  end

  assign O_GNT               = gnt_reg;
  assign O_VALID             = valid_reg;
  assign O_RDATA             = rdata_reg;
  assign O_BRAM_ADDRESS      = baddr_reg;
  assign O_BRAM_DATA         = bdata_reg;
  assign O_BRAM_WRITE_ENABLE = bwe_reg;

endmodule

// File: tb/tb_bram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bram_arbiter
//   Directed bench for bram_arbiter with a behavioural synchronous-read BRAM
//   on the arbitrated port. Honors BRAM_ARBITER_FIXED_PRIORITY_EN for the
//   tie-break expectations.
// ----------------------------------------------------------------------------
module tb_bram_arbiter;

`ifdef BRAM_ARBITER_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        I_CLK = 1'b0;
  logic        I_NRESET = 1'b0;
  logic [1:0]  I_REQ = '0;
  logic [1:0]  I_WE = '0;
  logic [31:0] I_ADDR = '0;
  logic [31:0] I_WDATA = '0;
  logic [1:0]  O_GNT, O_VALID;
  logic [15:0] O_RDATA, O_BRAM_ADDRESS, O_BRAM_DATA, I_BRAM_DATA;
  logic        O_BRAM_WRITE_ENABLE;

  always #5 I_CLK = ~I_CLK;

  bram_arbiter dut (
    .I_CLK               (I_CLK),
    .I_NRESET            (I_NRESET),
    .I_REQ               (I_REQ),
    .I_WE                (I_WE),
    .I_ADDR              (I_ADDR),
    .I_WDATA             (I_WDATA),
    .O_GNT               (O_GNT),
    .O_VALID             (O_VALID),
    .O_RDATA             (O_RDATA),
    .O_BRAM_ADDRESS      (O_BRAM_ADDRESS),
    .O_BRAM_DATA         (O_BRAM_DATA),
    .O_BRAM_WRITE_ENABLE (O_BRAM_WRITE_ENABLE),
    .I_BRAM_DATA         (I_BRAM_DATA)
  );

  // Behavioural single-port view of the bram: synchronous write and read.
  logic [15:0] mem [0:65535];
  always @(posedge I_CLK) begin
    if (O_BRAM_WRITE_ENABLE) mem[O_BRAM_ADDRESS] <= O_BRAM_DATA;
    I_BRAM_DATA <= mem[O_BRAM_ADDRESS];
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] a0, a1, d0, d1;
    logic [1:0]  exp_gnt;
    logic        exp_we;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t        tbl [8];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] last_rd = 16'h0000;
  int          got [8];
  int          ng;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one request, check grant, WE pulse, completion timing and data.
  task automatic run_txn(input vec_t v, input string name);
    int cyc;
    @(negedge I_CLK);
    I_REQ   = v.req;
    I_WE    = v.we;
    I_ADDR  = {v.a1, v.a0};
    I_WDATA = {v.d1, v.d0};
    cyc = 0;
    do begin @(negedge I_CLK); cyc++; end while (O_GNT == 2'b00 && cyc < 20);
    chk({name, "_gnt"}, O_GNT, v.exp_gnt);
    chk({name, "_gnt_lat"}, cyc, 1);
    chk({name, "_we"}, O_BRAM_WRITE_ENABLE, v.exp_we);
    I_REQ = 2'b00;
    cyc = 0;
    do begin @(negedge I_CLK); cyc++; end while (O_VALID == 2'b00 && cyc < 20);
    chk({name, "_valid"}, O_VALID, v.exp_gnt);
    chk({name, "_valid_lat"}, cyc, v.exp_we ? 1 : 2);
    chk({name, "_we_off"}, O_BRAM_WRITE_ENABLE, 0);
    if (v.exp_we) begin
      chk({name, "_rdata_hold"}, O_RDATA, last_rd);
    end else begin
      chk({name, "_rdata"}, O_RDATA, v.exp_rdata);
      last_rd = v.exp_rdata;
    end
    $display("txn %s: gnt=%b valid=%b rdata=%h", name, v.exp_gnt, O_VALID, O_RDATA);
  endtask

  initial begin
    mem[16'h0020] = 16'h1234;
    mem[16'h0040] = 16'h7777;

    //           req    we     a0        a1        d0        d1        gnt    we    rdata
    tbl[0] = '{2'b01, 2'b01, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000, 2'b01, 1'b1, 16'h0000};
    tbl[1] = '{2'b10, 2'b00, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 2'b10, 1'b0, 16'hBEEF};
    tbl[2] = '{2'b01, 2'b00, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h1234};
    tbl[3] = '{2'b01, 2'b01, 16'h0020, 16'h0000, 16'h1235, 16'h0000, 2'b01, 1'b1, 16'h0000};
    tbl[4] = '{2'b01, 2'b00, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h1235};
    // Tie after requester 0 was served: round-robin picks 1, fixed picks 0.
    tbl[5] = '{2'b11, 2'b00, 16'h0010, 16'h0020, 16'h0000, 16'h0000,
               FIXED ? 2'b01 : 2'b10, 1'b0, FIXED ? 16'hBEEF : 16'h1235};
    tbl[6] = '{2'b10, 2'b10, 16'h0000, 16'h0030, 16'h0000, 16'h5A5A, 2'b10, 1'b1, 16'h0000};
    // Tie after requester 1 was served: both modes pick 0.
    tbl[7] = '{2'b11, 2'b00, 16'h0030, 16'h0010, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h5A5A};

    // Reset state.
    #2;
    chk("reset_outputs", {O_GNT, O_VALID, O_RDATA, O_BRAM_ADDRESS, O_BRAM_DATA, O_BRAM_WRITE_ENABLE}, 0);
    repeat (2) @(negedge I_CLK);
    I_NRESET = 1'b1;
    @(negedge I_CLK);
    chk("post_reset_outputs", {O_GNT, O_VALID, O_RDATA, O_BRAM_ADDRESS, O_BRAM_DATA, O_BRAM_WRITE_ENABLE}, 0);

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while in S_READ: no completion, outputs clear immediately.
    begin
      vec_t v;
      @(negedge I_CLK);
      I_REQ = 2'b01; I_WE = 2'b00; I_ADDR = {16'h0, 16'h0020};
      @(negedge I_CLK);
      chk("rstread_gnt", O_GNT, 2'b01);
      I_REQ = 2'b00;
      @(negedge I_CLK);            // now in S_READ
      I_NRESET = 1'b0;
      #1;
      chk("rstread_outputs", {O_GNT, O_VALID, O_RDATA, O_BRAM_ADDRESS, O_BRAM_DATA, O_BRAM_WRITE_ENABLE}, 0);
      repeat (2) begin
        @(negedge I_CLK);
        chk("rstread_no_valid", O_VALID, 2'b00);
      end
      I_NRESET = 1'b1;
      @(negedge I_CLK);
      chk("rstread_no_valid_after", O_VALID, 2'b00);
      last_rd = 16'h0000;
      v = '{2'b01, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'hBEEF};
      run_txn(v, "after_rstread");
    end

    // Reset while in S_ACCESS of a write: memory keeps its old word.
    begin
      vec_t v;
      @(negedge I_CLK);
      I_REQ = 2'b01; I_WE = 2'b01; I_ADDR = {16'h0, 16'h0040}; I_WDATA = {16'h0, 16'h9999};
      @(negedge I_CLK);
      chk("rstwr_gnt", O_GNT, 2'b01);
      chk("rstwr_we", O_BRAM_WRITE_ENABLE, 1);
      I_REQ = 2'b00;
      I_NRESET = 1'b0;
      #1;
      chk("rstwr_we_cleared", O_BRAM_WRITE_ENABLE, 0);
      repeat (2) @(negedge I_CLK);
      chk("rstwr_mem", mem[16'h0040], 16'h7777);
      I_NRESET = 1'b1;
      last_rd = 16'h0000;
      v = '{2'b01, 2'b00, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h7777};
      run_txn(v, "after_rstwr");
    end

    // Continuous contention right after reset: 0,1,0,1... (or all 0 fixed).
    @(negedge I_CLK);
    I_NRESET = 1'b0;
    @(negedge I_CLK);
    I_NRESET = 1'b1;
    I_REQ = 2'b11; I_WE = 2'b00; I_ADDR = {16'h0020, 16'h0010};
    ng = 0;
    for (int c = 0; c < 80 && ng < 8; c++) begin
      @(negedge I_CLK);
      if (O_VALID == 2'b11) chk("alt_valid_onehot", O_VALID, 2'b01);
      if (O_GNT != 2'b00) begin
        chk("alt_gnt_onehot", $onehot(O_GNT), 1);
        got[ng] = O_GNT[1] ? 1 : 0;
        $display("alt grant %0d -> requester %0d", ng, got[ng]);
        ng++;
      end
    end
    I_REQ = 2'b00;
    chk("alt_count", ng, 8);
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("alt_order%0d", i), got[i], FIXED ? 0 : (i % 2));
    end
    repeat (4) @(negedge I_CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
